kv_cmd_framer: RTL and testbench

- Byte-serial command framer for the key-value ledger: takes bytes from the UART receiver, decodes the opcode byte, assembles the key, value and transaction-kind fields, and presents one complete command to the hash/BRAM store over a valid/ready handshake.
- Replaces per-opcode handler instances with one clocked FSM.
- Generalised in key/value width.
- Adds timeout, unknown-opcode and overrun detection, plus saturating frame statistics.

---
 rtl/kv_cmd_pkg.sv | 44 ++++
 rtl/kv_sat_counter.sv | 20 ++
 rtl/kv_cmd_framer.sv | 194 +++++++++++++++++++
 tb/tb_kv_cmd_framer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kv_cmd_pkg.sv
// Shared definitions for the key-value command framer: wire opcodes,
// store-side operation encoding and the framer FSM states.
package kv_cmd_pkg;

  // Opcode bytes as they arrive from the UART
  localparam logic [7:0] OPC_ISSUE    = 8'h01;
  localparam logic [7:0] OPC_TRANSFER = 8'h02;
  localparam logic [7:0] OPC_REFER    = 8'h03;
  localparam logic [7:0] OPC_CREATE   = 8'h04;

  // Operation encoding presented to the hash/BRAM store
  localparam logic [1:0] OP_REFER    = 2'd0;
  localparam logic [1:0] OP_ISSUE    = 2'd1;
  localparam logic [1:0] OP_TRANSFER = 2'd2;
  localparam logic [1:0] OP_CREATE   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KIND,
    ST_KEY,
    ST_VALUE,
    ST_HOLD
  } fsm_state_t;

  function automatic logic opc_known(input logic [7:0] b);
    return (b == OPC_ISSUE) || (b == OPC_TRANSFER) ||
           (b == OPC_REFER) || (b == OPC_CREATE);
  endfunction

  // ISSUE and TRANSFER carry a kind byte right after the opcode
  function automatic logic opc_has_kind(input logic [7:0] b);
    return (b == OPC_ISSUE) || (b == OPC_TRANSFER);
  endfunction

  function automatic logic [1:0] opc_to_op(input logic [7:0] b);
    case (b)
      OPC_ISSUE:    return OP_ISSUE;
      OPC_TRANSFER: return OP_TRANSFER;
      OPC_CREATE:   return OP_CREATE;
      default:      return OP_REFER;
    endcase
  endfunction

endpackage

// File: rtl/kv_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones.
module kv_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up until all-ones, then hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/kv_cmd_framer.sv
// Byte-serial command framer: decodes an opcode byte, collects the kind,
// key and value fields, and holds one complete command on a valid/ready
// interface. Flags unknown opcodes, stalled frames and bytes arriving while
// a command is still waiting, and keeps saturating frame statistics.
module kv_cmd_framer
  import kv_cmd_pkg::*;
#(
  parameter int KEY_BYTES      = 4,
  parameter int VAL_BYTES      = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [1:0]             cmd_op,
  output logic                   cmd_kind,
  output logic [8*KEY_BYTES-1:0] cmd_key,
  output logic [8*VAL_BYTES-1:0] cmd_value,
  output logic                   err_opcode,
  output logic                   err_timeout,
  output logic                   err_overrun,
  output logic [CNT_W-1:0]       frames_ok,
  output logic [CNT_W-1:0]       frames_err
);

  localparam int KW    = 8 * KEY_BYTES;
  localparam int VW    = 8 * VAL_BYTES;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [3:0] KEY_LAST = 4'(KEY_BYTES - 1);
  localparam logic [3:0] VAL_LAST = 4'(VAL_BYTES - 1);

  fsm_state_t       state, state_n;
  logic [3:0]       byte_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic take_op;   // rx_data is interpreted as an opcode this cycle
  logic op_start;  // ... and it is a known opcode
  logic op_bad;
  logic tmo_exp;
  logic tmo_hit;
  logic overrun;
  logic hs;
  logic kind_ld;
  logic key_sh;
  logic val_sh;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    state_n  = state;
    take_op  = 1'b0;
    op_start = 1'b0;
    op_bad   = 1'b0;
    tmo_hit  = 1'b0;
    overrun  = 1'b0;
    hs       = 1'b0;
    kind_ld  = 1'b0;
    key_sh   = 1'b0;
    val_sh   = 1'b0;
    tmo_exp  = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);
    case (state)
      ST_IDLE: take_op = rx_valid;
      ST_KIND: begin
        if (rx_valid) begin
          kind_ld = 1'b1;
          state_n = ST_KEY;
        end else if (tmo_exp) begin
          tmo_hit = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_KEY: begin
        if (rx_valid) begin
          key_sh = 1'b1;
          if (byte_cnt == KEY_LAST)
            state_n = (cmd_op == OP_REFER) ? ST_HOLD : ST_VALUE;
        end else if (tmo_exp) begin
          tmo_hit = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_VALUE: begin
        if (rx_valid) begin
          val_sh = 1'b1;
          if (byte_cnt == VAL_LAST) state_n = ST_HOLD;
        end else if (tmo_exp) begin
          tmo_hit = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // A byte landing in the handshake cycle is the next opcode
        if (cmd_ready) begin
          hs      = 1'b1;
          state_n = ST_IDLE;
          take_op = rx_valid;
        end else begin
          overrun = rx_valid;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (take_op) begin
      if (opc_known(rx_data)) begin
        op_start = 1'b1;
        state_n  = opc_has_kind(rx_data) ? ST_KIND : ST_KEY;
      end else begin
        op_bad = 1'b1;
      end
    end
  end

  // Byte and inter-byte idle counters, both restarted on every state change
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt <= '0;
      tmo_cnt  <= '0;
    end else if (state_n != state) begin
      byte_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      if (key_sh || val_sh) byte_cnt <= byte_cnt + 4'd1;
      if (rx_valid)
        tmo_cnt <= '0;
      else if (state == ST_KIND || state == ST_KEY || state == ST_VALUE)
        tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Command field registers; a new opcode or a timeout wipes old contents
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_op    <= OP_REFER;
      cmd_kind  <= 1'b0;
      cmd_key   <= '0;
      cmd_value <= '0;
    end else if (op_start) begin
      cmd_op    <= opc_to_op(rx_data);
      cmd_kind  <= 1'b0;
      cmd_key   <= '0;
      cmd_value <= '0;
    end else if (tmo_hit) begin
      cmd_op    <= OP_REFER;
      cmd_kind  <= 1'b0;
      cmd_key   <= '0;
      cmd_value <= '0;
    end else begin
      if (kind_ld) cmd_kind  <= rx_data[0];
      if (key_sh)  cmd_key   <= KW'({cmd_key, rx_data});
      if (val_sh)  cmd_value <= VW'({cmd_value, rx_data});
    end
  end

  // Registered one-cycle error pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_opcode  <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_opcode  <= op_bad;
      err_timeout <= tmo_hit;
      err_overrun <= overrun;
    end
  end

  assign cmd_valid = (state == ST_HOLD);

  kv_sat_counter #(.CNT_W(CNT_W)) u_cnt_ok (
    .clk   (clk),
    .reset (reset),
    .inc   (hs),
    .count (frames_ok)
  );

  kv_sat_counter #(.CNT_W(CNT_W)) u_cnt_err (
    .clk   (clk),
    .reset (reset),
    .inc   (op_bad | tmo_hit),
    .count (frames_err)
  );

endmodule

// File: tb/tb_kv_cmd_framer.sv
// Directed bench for kv_cmd_framer: a 4/4-byte instance with a short timeout
// and a 2/8-byte instance with tiny counters and the timeout disabled.
module tb_kv_cmd_framer;
  import kv_cmd_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic        cmd_kind;
  logic [31:0] cmd_key;
  logic [31:0] cmd_value;
  logic        err_opcode, err_timeout, err_overrun;
  logic [15:0] frames_ok, frames_err;

  logic [7:0]  rx_data2 = 8'h00;
  logic        rx_valid2 = 1'b0;
  logic        cmd_ready2 = 1'b1;
  logic        cmd_valid2;
  logic [1:0]  cmd_op2;
  logic        cmd_kind2;
  logic [15:0] cmd_key2;
  logic [63:0] cmd_value2;
  logic        err_opcode2, err_timeout2, err_overrun2;
  logic [1:0]  frames_ok2, frames_err2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  kv_cmd_framer #(.KEY_BYTES(4), .VAL_BYTES(4), .TIMEOUT_CYCLES(50), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_kind(cmd_kind), .cmd_key(cmd_key), .cmd_value(cmd_value),
    .err_opcode(err_opcode), .err_timeout(err_timeout), .err_overrun(err_overrun),
    .frames_ok(frames_ok), .frames_err(frames_err)
  );

  kv_cmd_framer #(.KEY_BYTES(2), .VAL_BYTES(8), .TIMEOUT_CYCLES(0), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .rx_data(rx_data2), .rx_valid(rx_valid2),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_op(cmd_op2),
    .cmd_kind(cmd_kind2), .cmd_key(cmd_key2), .cmd_value(cmd_value2),
    .err_opcode(err_opcode2), .err_timeout(err_timeout2), .err_overrun(err_overrun2),
    .frames_ok(frames_ok2), .frames_err(frames_err2)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the byte is consumed on the next rising edge
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [127:0] data, input int n);
    for (int i = 0; i < n; i++) send(data[8*(n-1-i) +: 8]);
  endtask

  task automatic send2(input logic [7:0] b);
    rx_data2  = b;
    rx_valid2 = 1'b1;
    @(negedge clk);
    rx_valid2 = 1'b0;
  endtask

  task automatic send2_bytes(input logic [127:0] data, input int n);
    for (int i = 0; i < n; i++) send2(data[8*(n-1-i) +: 8]);
  endtask

  initial begin
    int  cyc;
    bit  seen;
    bit  vld_seen;
    bit  tmo2_seen;

    repeat (2) @(negedge clk);
    check_val("rst_valid", cmd_valid, 0);
    check_val("rst_key", cmd_key, 0);
    check_val("rst_ok", frames_ok, 0);
    check_val("rst_errs", {err_opcode, err_timeout, err_overrun}, 0);
    reset = 1'b1;
    @(negedge clk);

    // CREATE with the store ready
    cmd_ready = 1'b1;
    send_bytes(128'h04DEADBEEF000001, 8);
    check_val("create_early_valid", cmd_valid, 0);
    send(8'h2C);
    check_val("create_valid", cmd_valid, 1);
    check_val("create_op", cmd_op, OP_CREATE);
    check_val("create_key", cmd_key, 32'hDEADBEEF);
    check_val("create_value", cmd_value, 32'h0000012C);
    check_val("create_kind", cmd_kind, 0);
    @(negedge clk);
    check_val("create_valid_drop", cmd_valid, 0);
    check_val("create_ok", frames_ok, 1);

    // ISSUE held under backpressure, with a stray byte while holding
    cmd_ready = 1'b0;
    send_bytes(128'h01010000000700000064, 10);
    check_val("issue_valid", cmd_valid, 1);
    check_val("issue_op", cmd_op, OP_ISSUE);
    check_val("issue_kind", cmd_kind, 1);
    check_val("issue_key", cmd_key, 32'h7);
    check_val("issue_value", cmd_value, 32'h64);
    repeat (2) @(negedge clk);
    send(8'h55);
    check_val("ovr_pulse", err_overrun, 1);
    check_val("ovr_valid", cmd_valid, 1);
    check_val("ovr_key", cmd_key, 32'h7);
    check_val("ovr_value", cmd_value, 32'h64);
    check_val("ovr_err_cnt", frames_err, 0);
    @(negedge clk);
    check_val("ovr_pulse_end", err_overrun, 0);
    check_val("ovr_ok_hold", frames_ok, 1);
    cmd_ready = 1'b1;
    @(negedge clk);
    check_val("issue_valid_drop", cmd_valid, 0);
    check_val("issue_ok", frames_ok, 2);

    // REFER, then the next opcode arrives in the handshake cycle
    cmd_ready = 1'b0;
    send_bytes(128'h0300000007, 5);
    check_val("refer_valid", cmd_valid, 1);
    check_val("refer_op", cmd_op, OP_REFER);
    check_val("refer_key", cmd_key, 32'h7);
    check_val("refer_value", cmd_value, 0);
    check_val("refer_kind", cmd_kind, 0);
    cmd_ready = 1'b1;
    send(OPC_TRANSFER);
    check_val("b2b_valid", cmd_valid, 0);
    check_val("b2b_ok", frames_ok, 3);
    check_val("b2b_op", cmd_op, OP_TRANSFER);
    send_bytes(128'h000000000A0000000B, 9);
    check_val("xfer_valid", cmd_valid, 1);
    check_val("xfer_kind", cmd_kind, 0);
    check_val("xfer_key", cmd_key, 32'hA);
    check_val("xfer_value", cmd_value, 32'hB);
    @(negedge clk);
    check_val("xfer_ok", frames_ok, 4);

    // Unknown opcode, then a good frame
    send(8'h09);
    check_val("badop_pulse", err_opcode, 1);
    check_val("badop_err_cnt", frames_err, 1);
    check_val("badop_valid", cmd_valid, 0);
    @(negedge clk);
    check_val("badop_pulse_end", err_opcode, 0);
    send_bytes(128'h040102030405060708, 9);
    check_val("after_bad_key", cmd_key, 32'h01020304);
    check_val("after_bad_value", cmd_value, 32'h05060708);
    @(negedge clk);
    check_val("after_bad_ok", frames_ok, 5);

    // Frame stalls after two key bytes
    send_bytes(128'h041122, 3);
    seen = 1'b0;
    vld_seen = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 200 && !seen; i++) begin
      @(negedge clk);
      if (cmd_valid) vld_seen = 1'b1;
      if (err_timeout) begin
        seen = 1'b1;
        cyc  = i;
      end
    end
    check_val("tmo_cycles", cyc, 50);
    check_val("tmo_no_valid", vld_seen, 0);
    check_val("tmo_err_cnt", frames_err, 2);
    @(negedge clk);
    check_val("tmo_pulse_end", err_timeout, 0);
    send_bytes(128'h04AABBCCDD00000001, 9);
    check_val("after_tmo_key", cmd_key, 32'hAABBCCDD);
    check_val("after_tmo_value", cmd_value, 32'h1);
    @(negedge clk);
    check_val("after_tmo_ok", frames_ok, 6);

    // Reset in the middle of the value field
    cmd_ready = 1'b0;
    send_bytes(128'h040102030405, 6);
    reset = 1'b0;
    #1;
    check_val("rstv_valid", cmd_valid, 0);
    check_val("rstv_ok", frames_ok, 0);
    check_val("rstv_err", frames_err, 0);
    check_val("rstv_key", cmd_key, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset while a command is held
    send_bytes(128'h041111111122222222, 9);
    check_val("rsth_pre_valid", cmd_valid, 1);
    reset = 1'b0;
    #1;
    check_val("rsth_valid", cmd_valid, 0);
    check_val("rsth_value", cmd_value, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("rsth_still_idle", cmd_valid, 0);
    send_bytes(128'h040A0B0C0D0000000E, 9);
    check_val("post_rst_key", cmd_key, 32'h0A0B0C0D);
    cmd_ready = 1'b1;
    @(negedge clk);
    check_val("post_rst_ok", frames_ok, 1);
    cmd_ready = 1'b0;

    // Second instance: 2-byte key, 8-byte value, 2-bit counters, no timeout
    send2_bytes(128'h041234, 3);
    tmo2_seen = 1'b0;
    repeat (120) begin
      @(negedge clk);
      if (err_timeout2) tmo2_seen = 1'b1;
    end
    check_val("w_no_timeout", tmo2_seen, 0);
    send2_bytes(128'h0102030405060708, 8);
    check_val("w_valid", cmd_valid2, 1);
    check_val("w_op", cmd_op2, OP_CREATE);
    check_val("w_key", cmd_key2, 16'h1234);
    check_val("w_value", cmd_value2, 64'h0102030405060708);
    @(negedge clk);
    check_val("w_ok_1", frames_ok2, 1);
    for (int k = 2; k <= 4; k++) begin
      send2_bytes(128'h04ABCD1122334455667788, 11);
      check_val("w_value_n", cmd_value2, 64'h1122334455667788);
      @(negedge clk);
      check_val("w_ok_sat", frames_ok2, (k > 3) ? 3 : k);
    end
    check_val("w_err_cnt", frames_err2, 0);
    check_val("w_errs", {err_opcode2, err_overrun2, cmd_kind2}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
